// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between mem_access_unit (master) and data memory (slave).
// Single outstanding request: mem_req held until mem_ready.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory side of the load/store path.
// Accepts one access per instruction, stalls the core while a single
// req/ready transaction runs, builds byte-lane masks / replicated store data,
// and sign/zero-extends load results.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// accesses (no bus request, misaligned pulse with done) instead of
// truncating the low address bits.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               memory_en,
  input  logic [1:0]         store_size,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic               done,
  output logic [31:0]        rdata,
  output logic               bus_err,
  output logic               misaligned,
  mem_access_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        is_load;
  logic [3:0]  cap_mask;
  logic [31:0] cap_wdata;
  logic        trap;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ext;

  // Lane mask / replicated data for the access presented in IDLE
  always_comb begin
    is_load   = (store_size == 2'b11);
    cap_mask  = '0;
    cap_wdata = '0;
    case (store_size)
      2'b00: begin
        cap_mask  = 4'b0001 << addr[1:0];
        cap_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        cap_mask  = addr[1] ? 4'b1100 : 4'b0011;
        cap_wdata = {2{wdata[15:0]}};
      end
      2'b10: begin
        cap_mask  = 4'b1111;
        cap_wdata = wdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  // Misalignment detect: half needs addr[0]=0, word/LW needs addr[1:0]=0
  always_comb begin
    trap = 1'b0;
    if (!is_load) begin
      if (store_size == 2'b01) trap = addr[0];
      else if (store_size == 2'b10) trap = (addr[1:0] != 2'b00);
    end else begin
      case (funct3)
        3'b000, 3'b100: trap = 1'b0;
        3'b001, 3'b101: trap = addr[0];
        default:        trap = (addr[1:0] != 2'b00);
      endcase
    end
  end
`else
  // Low address bits are truncated instead of trapped
  always_comb trap = 1'b0;
`endif

  // Load extraction from the returned word using captured offset/type
  always_comb begin
    sel_b = bus.mem_rdata[{off_q, 3'b000} +: 8];
    sel_h = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{sel_b[7]}}, sel_b};
      3'b001:  ext = {{16{sel_h[15]}}, sel_h};
      3'b100:  ext = {24'h0, sel_b};
      3'b101:  ext = {16'h0, sel_h};
      default: ext = bus.mem_rdata;
    endcase
  end

  // Stall is combinational in IDLE so the PC freezes in the accepting cycle
  always_comb begin
    case (state)
      IDLE:    stall = memory_en;
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Transaction FSM with registered bus and status outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      f3_q           <= '0;
      off_q          <= '0;
      done           <= 1'b0;
      bus_err        <= 1'b0;
      misaligned     <= 1'b0;
      rdata          <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wmask  <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      done       <= 1'b0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (memory_en) begin
            if (trap) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
              state      <= DONE;
            end else begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= !is_load;
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_wmask <= cap_mask;
              bus.mem_wdata <= cap_wdata;
              f3_q          <= funct3;
              off_q         <= addr[1:0];
              cnt           <= '0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) rdata <= ext;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            bus.mem_req <= 1'b0;
            bus_err     <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors with
// hand-computed bus and result values, plus sequences for wait states,
// timeout, mid-transaction reset and misaligned word load.
module tb_mem_access_unit;
  logic        CLK = 1'b0;
  logic        reset;
  logic        memory_en;
  logic [1:0]  store_size;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, done, bus_err, misaligned;
  logic [31:0] rdata;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .memory_en  (memory_en),
    .store_size (store_size),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .bus_err    (bus_err),
    .misaligned (misaligned),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  ss;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(input logic [1:0] ss, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int waits,
                              input logic e_we, input logic [31:0] e_addr,
                              input logic [3:0] e_mask, input logic [31:0] e_wdata,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.ss = ss; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.waits = waits;
    v.e_we = e_we; v.e_addr = e_addr; v.e_mask = e_mask;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic do_access(input vec_t v, input string tag);
    @(negedge CLK);
    memory_en  = 1'b1;
    store_size = v.ss;
    funct3     = v.f3;
    addr       = v.a;
    wdata      = v.wd;
    #1 chk({tag, " stall_accept"}, 32'(stall), 32'd1);
    @(posedge CLK); #1;
    memory_en = 1'b0;
    for (int i = 0; i <= v.waits; i++) begin
      chk($sformatf("%s req[%0d]", tag, i), 32'(bus.mem_req), 32'd1);
      chk($sformatf("%s stall[%0d]", tag, i), 32'(stall), 32'd1);
      chk($sformatf("%s we[%0d]", tag, i), 32'(bus.mem_we), 32'(v.e_we));
      chk($sformatf("%s addr[%0d]", tag, i), bus.mem_addr, v.e_addr);
      chk($sformatf("%s mask[%0d]", tag, i), 32'(bus.mem_wmask), 32'(v.e_mask));
      if (v.e_we)
        chk($sformatf("%s wdata[%0d]", tag, i), bus.mem_wdata, v.e_wdata);
      chk($sformatf("%s early_done[%0d]", tag, i), 32'(done), 32'd0);
      if (i == v.waits) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = v.rd;
      end
      @(posedge CLK); #1;
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall_done"}, 32'(stall), 32'd0);
    chk({tag, " req_done"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, " misaligned"}, 32'(misaligned), 32'd0);
    chk({tag, " rdata"}, rdata, v.e_rdata);
    @(posedge CLK); #1;
    chk({tag, " done_once"}, 32'(done), 32'd0);
  endtask

  vec_t vecs [12];
  vec_t lw_mis;
  int   n;

  initial begin
    vecs[0]  = mk(2'b00, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,         0, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0000_0000);
    vecs[1]  = mk(2'b11, 3'b000, 32'h0000_2002, 32'h0,         32'h80FF_1234, 0, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'hFFFF_FFFF);
    vecs[2]  = mk(2'b11, 3'b100, 32'h0000_2002, 32'h0,         32'h80FF_1234, 0, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'h0000_00FF);
    vecs[3]  = mk(2'b11, 3'b001, 32'h0000_2002, 32'h0,         32'h80FF_1234, 0, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'hFFFF_80FF);
    vecs[4]  = mk(2'b11, 3'b101, 32'h0000_2002, 32'h0,         32'h80FF_1234, 0, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'h0000_80FF);
    vecs[5]  = mk(2'b01, 3'b000, 32'h0000_3002, 32'h1234_ABCD, 32'h0,         3, 1'b1, 32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 32'h0000_80FF);
    vecs[6]  = mk(2'b11, 3'b010, 32'h0000_5000, 32'h0,         32'hDEAD_BEEF, 1, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
    vecs[7]  = mk(2'b00, 3'b000, 32'h0000_6000, 32'h0000_005A, 32'h0,         2, 1'b1, 32'h0000_6000, 4'b0001, 32'h5A5A_5A5A, 32'hDEAD_BEEF);
    vecs[8]  = mk(2'b10, 3'b000, 32'h0000_7004, 32'hCAFE_F00D, 32'h0,         0, 1'b1, 32'h0000_7004, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    vecs[9]  = mk(2'b11, 3'b100, 32'h0000_8001, 32'h0,         32'h1122_3344, 0, 1'b0, 32'h0000_8000, 4'b0000, 32'h0,         32'h0000_0033);
    vecs[10] = mk(2'b11, 3'b001, 32'h0000_8000, 32'h0,         32'h1234_F00D, 0, 1'b0, 32'h0000_8000, 4'b0000, 32'h0,         32'hFFFF_F00D);
    vecs[11] = mk(2'b11, 3'b011, 32'h0000_9000, 32'h0,         32'h0BAD_CAFE, 0, 1'b0, 32'h0000_9000, 4'b0000, 32'h0,         32'h0BAD_CAFE);

    reset = 1'b1; memory_en = 1'b0; store_size = 2'b00; funct3 = 3'b000;
    addr = '0; wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;

    chk("rst stall", 32'(stall), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst misaligned", 32'(misaligned), 32'd0);
    chk("rst req", 32'(bus.mem_req), 32'd0);
    chk("rst we", 32'(bus.mem_we), 32'd0);
    chk("rst addr", bus.mem_addr, 32'h0);
    chk("rst mask", 32'(bus.mem_wmask), 32'd0);
    chk("rst wdata", bus.mem_wdata, 32'h0);

    for (int k = 0; k < 12; k++)
      do_access(vecs[k], $sformatf("vec%0d", k));

    // Timeout: LW with ready stuck low, rdata must stay at previous value
    @(negedge CLK);
    memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010; addr = 32'h0000_A000;
    @(posedge CLK); #1;
    memory_en = 1'b0;
    n = 0;
    while (bus.mem_req && n < 20) begin
      chk($sformatf("to stall[%0d]", n), 32'(stall), 32'd1);
      n++;
      @(posedge CLK); #1;
    end
    chk("to req_cycles", 32'(n), 32'd4);
    chk("to done", 32'(done), 32'd1);
    chk("to bus_err", 32'(bus_err), 32'd1);
    chk("to stall_rel", 32'(stall), 32'd0);
    chk("to rdata", rdata, 32'h0BAD_CAFE);
    @(posedge CLK); #1;
    chk("to done_once", 32'(done), 32'd0);
    chk("to err_once", 32'(bus_err), 32'd0);

    // Reset in REQ aborts; a late ready afterwards is ignored
    @(negedge CLK);
    memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010; addr = 32'h0000_B000;
    @(posedge CLK); #1;
    memory_en = 1'b0;
    chk("rr req_before", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    chk("rr req", 32'(bus.mem_req), 32'd0);
    chk("rr stall", 32'(stall), 32'd0);
    chk("rr done", 32'(done), 32'd0);
    chk("rr rdata", rdata, 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    chk("rr late_done", 32'(done), 32'd0);
    chk("rr late_rdata", rdata, 32'h0);
    chk("rr late_req", 32'(bus.mem_req), 32'd0);

    // Misaligned word load
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    @(negedge CLK);
    memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010; addr = 32'h0000_4001;
    @(posedge CLK); #1;
    memory_en = 1'b0;
    chk("mis req", 32'(bus.mem_req), 32'd0);
    chk("mis done", 32'(done), 32'd1);
    chk("mis flag", 32'(misaligned), 32'd1);
    chk("mis stall", 32'(stall), 32'd0);
    chk("mis rdata", rdata, 32'h0);
    @(posedge CLK); #1;
    chk("mis done_once", 32'(done), 32'd0);
    chk("mis flag_once", 32'(misaligned), 32'd0);
`else
    lw_mis = mk(2'b11, 3'b010, 32'h0000_4001, 32'h0, 32'h1357_9BDF, 0, 1'b0,
                32'h0000_4000, 4'b0000, 32'h0, 32'h1357_9BDF);
    do_access(lw_mis, "lw_mis");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
